// File: rtl/conv2d_systolic_param.sv
// Parametrised 2-D convolution engine: captures image and filter on start, then
// evaluates each output pixel as a sequence of P-wide tap groups.
module conv2d_systolic_param #(
    parameter int DW     = 8,
    parameter int IN_DIM = 4,
    parameter int K      = 3,
    parameter int P      = 3,
    parameter int SAT    = 0,
    parameter int SHIFT  = 0
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         start,
    input  logic [IN_DIM*IN_DIM*DW-1:0]                  img,
    input  logic [K*K*DW-1:0]                            flt,
    output logic                                         busy,
    output logic                                         done,
    output logic                                         out_valid,
    output logic [(IN_DIM-K+1)*(IN_DIM-K+1)*DW-1:0]      out
);

    localparam int OUT_DIM = IN_DIM - K + 1;
    localparam int TAPS    = K * K;
    localparam int G       = (TAPS + P - 1) / P;
    localparam int NOUT    = OUT_DIM * OUT_DIM;
    localparam int NIMG    = IN_DIM * IN_DIM;
    localparam int AW      = 2 * DW + $clog2(TAPS);
    localparam int OW      = (NOUT > 1) ? $clog2(NOUT) : 1;
    localparam int GW      = (G > 1) ? $clog2(G) : 1;
    localparam int IW      = (NIMG > 1) ? $clog2(NIMG) : 1;
    localparam int FW      = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [AW-1:0] MAXV = AW'({DW{1'b1}});

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t               state_q;
    logic [OW-1:0]        o_q;
    logic [GW-1:0]        g_q;
    logic [AW-1:0]        acc_q;
    logic [AW-1:0]        acc_d;
    logic                 busy_q;
    logic                 done_q;
    logic                 valid_q;
    logic [DW-1:0]        res_q [NOUT];
    logic [NIMG*DW-1:0]   img_q;
    logic [TAPS*DW-1:0]   flt_q;
    logic [DW-1:0]        img_e [NIMG];
    logic [DW-1:0]        flt_e [TAPS];
    logic                 accept;

    assign accept = (state_q == S_IDLE) && start;

    // Operand copies are data-only registers; they load solely on an accepted start.
    always_ff @(posedge clk) begin
        if (accept) begin
            img_q <= img;
            flt_q <= flt;
        end
    end

    for (genvar i = 0; i < NIMG; i++) begin : g_img
        assign img_e[i] = img_q[i*DW +: DW];
    end
    for (genvar i = 0; i < TAPS; i++) begin : g_flt
        assign flt_e[i] = flt_q[i*DW +: DW];
    end

    // Product of one tap for output slot oi; padding taps of the last group give zero.
    function automatic logic [2*DW-1:0] tap_product(input int oi, input int t);
        int r;
        int c;
        int kr;
        int kc;
        if (t >= TAPS) return '0;
        r  = oi / OUT_DIM;
        c  = oi % OUT_DIM;
        kr = t / K;
        kc = t % K;
        return img_e[IW'((r + kr) * IN_DIM + c + kc)] * flt_e[FW'(t)];
    endfunction

    function automatic logic [DW-1:0] post_proc(input logic [AW-1:0] s);
        logic [AW-1:0] sh;
        sh = s >> SHIFT;
        if ((SAT != 0) && (sh > MAXV)) return '1;
        return sh[DW-1:0];
    endfunction

    always_comb begin
        acc_d = acc_q;
        for (int l = 0; l < P; l++) begin
            acc_d = acc_d + AW'(tap_product(int'(o_q), int'(g_q) * P + l));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            o_q     <= '0;
            g_q     <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            for (int i = 0; i < NOUT; i++) res_q[i] <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b0;
                        o_q     <= '0;
                        g_q     <= '0;
                        acc_q   <= '0;
                    end
                end
                S_RUN: begin
                    if (g_q == GW'(G - 1)) begin
                        res_q[o_q] <= post_proc(acc_d);
                        acc_q      <= '0;
                        g_q        <= '0;
                        if (o_q == OW'(NOUT - 1)) begin
                            state_q <= S_FIN;
                            busy_q  <= 1'b0;
                        end else begin
                            o_q <= o_q + 1'b1;
                        end
                    end else begin
                        acc_q <= acc_d;
                        g_q   <= g_q + 1'b1;
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b1;
                    valid_q <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = valid_q;

    for (genvar i = 0; i < NOUT; i++) begin : g_out
        assign out[i*DW +: DW] = res_q[i];
    end

endmodule

// File: tb/tb_conv2d_systolic_param.sv
// Scoreboard bench: a default engine (P=3, wrap) and a P=9 saturating engine share operands.
module tb_conv2d_systolic_param;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         start2;
    logic [127:0] img;
    logic [71:0]  flt;
    logic         busy1, done1, ov1;
    logic [31:0]  out1;
    logic         busy2, done2, ov2;
    logic [31:0]  out2;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] res;
        int          done_cyc;
        int          busy_n;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    localparam logic [127:0] IMG_A = {8'd9, 8'd9, 8'd2, 8'd2, 8'd1, 8'd1, 8'd10, 8'd4,
                                      8'd6, 8'd1, 8'd4, 8'd0, 8'd6, 8'd2, 8'd8, 8'd9};
    localparam logic [71:0]  FLT_A = {8'd1, 8'd1, 8'd3, 8'd1, 8'd0, 8'd2, 8'd0, 8'd2, 8'd3};
    localparam logic [31:0]  RES_A = {8'd59, 8'd34, 8'd74, 8'd67};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv2d_systolic_param u_dut (
        .clk(clk), .rst(rst), .start(start), .img(img), .flt(flt),
        .busy(busy1), .done(done1), .out_valid(ov1), .out(out1)
    );

    conv2d_systolic_param #(.P(9), .SAT(1)) u_sat (
        .clk(clk), .rst(rst), .start(start2), .img(img), .flt(flt),
        .busy(busy2), .done(done2), .out_valid(ov2), .out(out2)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_run(input string tag, input exp_t e, input logic [31:0] res,
                             input logic ov, input int bcnt);
        check({tag, "_out"}, 64'(res), 64'(e.res));
        check({tag, "_valid_at_done"}, 64'(ov), 64'd1);
        check({tag, "_done_cycle"}, 64'(cyc), 64'(e.done_cyc));
        check({tag, "_busy_cycles"}, 64'(bcnt), 64'(e.busy_n));
    endtask

    // Monitors: compare each presented result against the oldest expectation.
    int  bcnt1 = 0, bcnt2 = 0;
    logic pd1 = 1'b0, pd2 = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            bcnt1 = 0;
            pd1   = 1'b0;
        end else begin
            if (busy1) begin
                bcnt1++;
                check("p3_valid_low_while_busy", 64'(ov1), 64'd0);
            end
            if (done1) begin
                check("p3_done_single_pulse", 64'(pd1), 64'd0);
                if (q1.size() == 0) begin
                    check("p3_unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = q1.pop_front();
                    check_run("p3", e, out1, ov1, bcnt1);
                end
                bcnt1 = 0;
            end
            pd1 = done1;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            bcnt2 = 0;
            pd2   = 1'b0;
        end else begin
            if (busy2) begin
                bcnt2++;
                check("p9_valid_low_while_busy", 64'(ov2), 64'd0);
            end
            if (done2) begin
                check("p9_done_single_pulse", 64'(pd2), 64'd0);
                if (q2.size() == 0) begin
                    check("p9_unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = q2.pop_front();
                    check_run("p9", e, out2, ov2, bcnt2);
                end
                bcnt2 = 0;
            end
            pd2 = done2;
        end
    end

    task automatic push1(input logic [31:0] r, input int t0);
        q1.push_back('{res: r, done_cyc: t0 + 13, busy_n: 12});
    endtask

    task automatic push2(input logic [31:0] r, input int t0);
        q2.push_back('{res: r, done_cyc: t0 + 5, busy_n: 4});
    endtask

    task automatic drain(input int lim);
        int k;
        k = 0;
        while ((q1.size() != 0 || q2.size() != 0) && k < lim) begin
            tick(1);
            k++;
        end
        check("drain_pending_results", 64'(q1.size() + q2.size()), 64'd0);
        q1.delete();
        q2.delete();
        tick(2);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_p3_busy"},  64'(busy1), 64'd0);
        check({tag, "_p3_done"},  64'(done1), 64'd0);
        check({tag, "_p3_valid"}, 64'(ov1),   64'd0);
        check({tag, "_p3_out"},   64'(out1),  64'd0);
        check({tag, "_p9_busy"},  64'(busy2), 64'd0);
        check({tag, "_p9_valid"}, 64'(ov2),   64'd0);
        check({tag, "_p9_out"},   64'(out2),  64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        rst    = 1'b0;
        start  = 1'b0;
        start2 = 1'b0;
        img    = '0;
        flt    = '0;
        tick(2);
        check_idle_outputs("reset");
        rst = 1'b1;
        tick(1);

        // Reference vectors on both engines.
        img = IMG_A;
        flt = FLT_A;
        start = 1'b1;
        start2 = 1'b1;
        t0 = cyc + 1;
        push1(RES_A, t0);
        push2(RES_A, t0);
        tick(1);
        start = 1'b0;
        start2 = 1'b0;
        drain(60);

        // Full-scale operands: wrap keeps low bits of 585225, saturate clamps.
        img = {16{8'hFF}};
        flt = {9{8'hFF}};
        start = 1'b1;
        start2 = 1'b1;
        t0 = cyc + 1;
        push1({4{8'd9}}, t0);
        push2({4{8'd255}}, t0);
        tick(1);
        start = 1'b0;
        start2 = 1'b0;
        drain(60);

        // Reset in the middle of a run aborts it without a done pulse.
        img = IMG_A;
        flt = FLT_A;
        start = 1'b1;
        t0 = cyc + 1;
        push1(RES_A, t0);
        tick(1);
        start = 1'b0;
        tick(4);
        rst = 1'b0;
        #1;
        check_idle_outputs("midrun_reset");
        q1.delete();
        tick(2);
        rst = 1'b1;
        tick(20);
        start = 1'b1;
        t0 = cyc + 1;
        push1(RES_A, t0);
        tick(1);
        start = 1'b0;
        drain(60);

        // Operand changes and a second start during RUN must not disturb the run.
        start = 1'b1;
        t0 = cyc + 1;
        push1(RES_A, t0);
        tick(1);
        start = 1'b0;
        img = '0;
        flt = '0;
        tick(2);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        drain(60);

        // Start held high: runs accepted every 14 cycles.
        img = IMG_A;
        flt = FLT_A;
        start = 1'b1;
        t0 = cyc + 1;
        push1(RES_A, t0);
        push1(RES_A, t0 + 14);
        push1(RES_A, t0 + 28);
        tick(15);
        check("rerun_valid_cleared", 64'(ov1), 64'd0);
        tick(14);
        start = 1'b0;
        drain(80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
